// File: rtl/proc_seq_pkg.sv
// Shared encodings for the processor command sequencer: command opcodes,
// ALU operation codes, FSM state type and default widths.
package proc_seq_pkg;

  localparam int DEF_MEM_ADDR_W = 9;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MUL_WAIT   = 3;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_MEMWR = 3'b011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_MUL = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEMWR   = 3'd1,
    LD_RD   = 3'd2,
    LD_WB   = 3'd3,
    EX_HOLD = 3'd4,
    EX_WB   = 3'd5,
    ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/proc_sequencer.sv
// Turns single commands (ADD, MUL, LOAD, MEMWR) into cycle-by-cycle register,
// ALU and memory control strobes for a small processor datapath.
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MUL_WAIT   = DEF_MUL_WAIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [1:0]            cmd_rd,
  input  logic [1:0]            cmd_rs1,
  input  logic [1:0]            cmd_rs2,
  input  logic [MEM_ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0]     cmd_data,
  output logic                  reg_write_enable,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic [1:0]            reg_address1,
  output logic [1:0]            reg_address2,
  output logic [1:0]            alu_op,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0]     mem_data_in,
  output logic                  done,
  output logic                  err,
  output state_t                debug_state
);

  // Hold cycles count down to zero, so MUL loads MUL_WAIT-1 and ADD loads 0.
  localparam logic [3:0] MUL_HOLD = 4'(MUL_WAIT - 1);

  state_t     state;
  logic [1:0] rd_q;
  logic [3:0] wait_cnt;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, and all fields
  // are captured on that edge so the source may change them immediately.
  assign cmd_ready   = (state == IDLE);
  assign debug_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      rd_q             <= '0;
      wait_cnt         <= '0;
      reg_write_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      reg_address1     <= '0;
      reg_address2     <= '0;
      alu_op           <= '0;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      reg_write_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rd_q <= cmd_rd;
            case (cmd_op)
              OP_MEMWR: begin
                state            <= MEMWR;
                mem_write_enable <= 1'b1;
                mem_address      <= cmd_addr;
                mem_data_in      <= cmd_data;
                done             <= 1'b1;
              end
              OP_LOAD: begin
                state           <= LD_RD;
                mem_read_enable <= 1'b1;
                mem_address     <= cmd_addr;
              end
              OP_ADD, OP_MUL: begin
                state        <= EX_HOLD;
                reg_address1 <= cmd_rs1;
                reg_address2 <= cmd_rs2;
                alu_op       <= (cmd_op == OP_MUL) ? ALU_MUL : ALU_ADD;
                wait_cnt     <= (cmd_op == OP_MUL) ? MUL_HOLD : 4'd0;
              end
              default: begin
                state <= ERR;
                err   <= 1'b1;
              end
            endcase
          end
        end
        LD_RD: begin
          state            <= LD_WB;
          mem_read_enable  <= 1'b1;
          reg_write_enable <= 1'b1;
          reg_address1     <= rd_q;
          done             <= 1'b1;
        end
        EX_HOLD: begin
          // Operand addresses stay put while the multiplier settles.
          if (wait_cnt == 4'd0) begin
            state            <= EX_WB;
            reg_write_enable <= 1'b1;
            reg_address1     <= rd_q;
            done             <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        MEMWR, LD_WB, EX_WB, ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a small processor model (register
// file, memory, latched ALU result) that reacts to the sequencer strobes.
module tb_proc_sequencer;
  import proc_seq_pkg::*;

  localparam int MEM_ADDR_W = 9;
  localparam int DATA_W     = 32;
  localparam int MUL_WAIT   = 3;

  logic                  clk;
  logic                  reset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [1:0]            cmd_rd, cmd_rs1, cmd_rs2;
  logic [MEM_ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0]     cmd_data;
  logic                  reg_write_enable, mem_write_enable, mem_read_enable;
  logic [1:0]            reg_address1, reg_address2, alu_op;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0]     mem_data_in;
  logic                  done, err;
  state_t                debug_state;

  int vectors;
  int miscompares;

  proc_sequencer #(
    .MEM_ADDR_W(MEM_ADDR_W),
    .DATA_W    (DATA_W),
    .MUL_WAIT  (MUL_WAIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_rd          (cmd_rd),
    .cmd_rs1         (cmd_rs1),
    .cmd_rs2         (cmd_rs2),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .reg_write_enable(reg_write_enable),
    .mem_write_enable(mem_write_enable),
    .mem_read_enable (mem_read_enable),
    .reg_address1    (reg_address1),
    .reg_address2    (reg_address2),
    .alu_op          (alu_op),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .done            (done),
    .err             (err),
    .debug_state     (debug_state)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- processor model ----
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] mem [512];
  logic [DATA_W-1:0] alu_res;
  logic              preset_en;
  logic [1:0]        preset_idx;
  logic [DATA_W-1:0] preset_val;

  always @(posedge clk) begin
    if (preset_en) regs[preset_idx] <= preset_val;
    if (mem_write_enable) mem[mem_address] <= mem_data_in;
    if (reg_write_enable)
      regs[reg_address1] <= mem_read_enable ? mem[mem_address] : alu_res;
    else
      alu_res <= (alu_op == ALU_MUL) ? regs[reg_address1] * regs[reg_address2]
                                     : regs[reg_address1] + regs[reg_address2];
  end

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preset_reg(input logic [1:0] idx, input logic [DATA_W-1:0] val);
    preset_en  = 1'b1;
    preset_idx = idx;
    preset_val = val;
    step();
    preset_en  = 1'b0;
  endtask

  // Presents one command, lets the accepting edge pass, then scrambles the
  // fields; returns #1 into cycle T+1.
  task automatic drive_cmd(input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [MEM_ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_addr  = addr;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_rd    = 2'($urandom_range(0, 3));
    cmd_rs1   = 2'($urandom_range(0, 3));
    cmd_rs2   = 2'($urandom_range(0, 3));
    cmd_addr  = MEM_ADDR_W'($urandom);
    cmd_data  = $urandom;
  endtask

  // ---- tests ----
  // ctl vector order: {reg_we, mem_we, mem_re, done, err, cmd_ready}
  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_ctl got=%b exp=000001",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready});
    end
    vectors++;
    if ({reg_address1, reg_address2, alu_op, mem_address, mem_data_in} !== '0 || debug_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_values a1=%0d a2=%0d alu=%0d maddr=%0h mdata=%0h st=%0d exp all 0",
               reg_address1, reg_address2, alu_op, mem_address, mem_data_in, debug_state);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_memwr();
    drive_cmd(OP_MEMWR, 2'd0, 2'd0, 2'd0, 9'h001, 32'h0000000a);
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b010100 ||
        mem_address !== 9'h001 || mem_data_in !== 32'h0000000a) begin
      miscompares++;
      $display("FAIL memwr_t1 ctl=%b addr=%0h data=%0h exp ctl=010100 addr=1 data=a",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready},
               mem_address, mem_data_in);
    end
    step();
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b000001 ||
        mem_address !== 9'h001) begin
      miscompares++;
      $display("FAIL memwr_t2 ctl=%b addr=%0h exp ctl=000001 addr=1",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready}, mem_address);
    end
    vectors++;
    if (mem[1] !== 32'h0000000a) begin
      miscompares++;
      $display("FAIL memwr_mem got=%0h exp=a", mem[1]);
    end
  endtask

  task automatic test_load();
    drive_cmd(OP_MEMWR, 2'd0, 2'd0, 2'd0, 9'h005, 32'd5);
    step();
    drive_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 9'h005, 32'd0);
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b001000 ||
        mem_address !== 9'h005) begin
      miscompares++;
      $display("FAIL load_t1 ctl=%b addr=%0h exp ctl=001000 addr=5",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready}, mem_address);
    end
    step();
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b101100 ||
        reg_address1 !== 2'd1 || mem_address !== 9'h005) begin
      miscompares++;
      $display("FAIL load_t2 ctl=%b a1=%0d addr=%0h exp ctl=101100 a1=1 addr=5",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready},
               reg_address1, mem_address);
    end
    step();
    vectors++;
    if (cmd_ready !== 1'b1 || regs[1] !== 32'd5) begin
      miscompares++;
      $display("FAIL load_t3 ready=%b r1=%0d exp ready=1 r1=5", cmd_ready, regs[1]);
    end
  endtask

  task automatic test_add();
    preset_reg(2'd0, 32'd10);
    drive_cmd(OP_ADD, 2'd3, 2'd0, 2'd1, 9'h000, 32'd0);
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b000000 ||
        {reg_address1, reg_address2, alu_op} !== {2'd0, 2'd1, ALU_ADD}) begin
      miscompares++;
      $display("FAIL add_t1 ctl=%b a1=%0d a2=%0d alu=%0d exp ctl=000000 a1=0 a2=1 alu=0",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready},
               reg_address1, reg_address2, alu_op);
    end
    step();
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b100100 ||
        {reg_address1, reg_address2, alu_op} !== {2'd3, 2'd1, ALU_ADD}) begin
      miscompares++;
      $display("FAIL add_t2 ctl=%b a1=%0d a2=%0d alu=%0d exp ctl=100100 a1=3 a2=1 alu=0",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready},
               reg_address1, reg_address2, alu_op);
    end
    step();
    vectors++;
    if (cmd_ready !== 1'b1 || regs[3] !== 32'd15) begin
      miscompares++;
      $display("FAIL add_t3 ready=%b r3=%0d exp ready=1 r3=15", cmd_ready, regs[3]);
    end
  endtask

  task automatic test_mul();
    preset_reg(2'd2, 32'd20);
    preset_reg(2'd3, 32'd15);
    drive_cmd(OP_MUL, 2'd3, 2'd2, 2'd3, 9'h000, 32'd0);
    for (int i = 1; i <= MUL_WAIT; i++) begin
      vectors++;
      if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b000000 ||
          {reg_address1, reg_address2, alu_op} !== {2'd2, 2'd3, ALU_MUL}) begin
        miscompares++;
        $display("FAIL mul_hold_t%0d ctl=%b a1=%0d a2=%0d alu=%0d exp ctl=000000 a1=2 a2=3 alu=1",
                 i, {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready},
                 reg_address1, reg_address2, alu_op);
      end
      step();
    end
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b100100 ||
        {reg_address1, reg_address2, alu_op} !== {2'd3, 2'd3, ALU_MUL}) begin
      miscompares++;
      $display("FAIL mul_wb ctl=%b a1=%0d a2=%0d alu=%0d exp ctl=100100 a1=3 a2=3 alu=1",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready},
               reg_address1, reg_address2, alu_op);
    end
    step();
    vectors++;
    if (cmd_ready !== 1'b1 || regs[3] !== 32'd300) begin
      miscompares++;
      $display("FAIL mul_result ready=%b r3=%0d exp ready=1 r3=300", cmd_ready, regs[3]);
    end
  endtask

  // Illegal op, with the following ADD presented early (ignored while busy).
  task automatic test_illegal_back_to_back();
    drive_cmd(3'b111, 2'd0, 2'd1, 2'd3, 9'h000, 32'd0);
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b000010) begin
      miscompares++;
      $display("FAIL illegal_t1 ctl=%b exp=000010",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready});
    end
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_rd    = 2'd0;
    cmd_rs1   = 2'd1;
    cmd_rs2   = 2'd3;
    step();
    vectors++;
    if (cmd_ready !== 1'b1 || err !== 1'b0 || debug_state !== IDLE) begin
      miscompares++;
      $display("FAIL illegal_t2 ready=%b err=%b st=%0d exp ready=1 err=0 st=0", cmd_ready, err, debug_state);
    end
    step();
    cmd_valid = 1'b0;
    vectors++;
    if (debug_state !== EX_HOLD || {reg_address1, reg_address2} !== {2'd1, 2'd3}) begin
      miscompares++;
      $display("FAIL b2b_accept st=%0d a1=%0d a2=%0d exp st=4 a1=1 a2=3", debug_state, reg_address1, reg_address2);
    end
    step();
    vectors++;
    if (done !== 1'b1 || reg_write_enable !== 1'b1 || reg_address1 !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_wb done=%b we=%b a1=%0d exp done=1 we=1 a1=0", done, reg_write_enable, reg_address1);
    end
    step();
    vectors++;
    if (regs[0] !== 32'd305) begin
      miscompares++;
      $display("FAIL b2b_result r0=%0d exp=305", regs[0]);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive_cmd(OP_MUL, 2'd1, 2'd3, 2'd3, 9'h000, 32'd0);
    vectors++;
    if (debug_state !== EX_HOLD) begin
      miscompares++;
      $display("FAIL rstmul_hold st=%0d exp=4", debug_state);
    end
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if ({reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready} !== 6'b000001 ||
        debug_state !== IDLE || {reg_address1, reg_address2, alu_op} !== 6'd0) begin
      miscompares++;
      $display("FAIL rstmul_async ctl=%b st=%0d a1=%0d a2=%0d alu=%0d exp ctl=000001 st=0 rest 0",
               {reg_write_enable, mem_write_enable, mem_read_enable, done, err, cmd_ready},
               debug_state, reg_address1, reg_address2, alu_op);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (done !== 1'b0 || reg_write_enable !== 1'b0 || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rstmul_quiet cyc%0d done=%b we=%b ready=%b exp 0 0 1", i, done, reg_write_enable, cmd_ready);
      end
    end
    vectors++;
    if (regs[1] !== 32'd5) begin
      miscompares++;
      $display("FAIL rstmul_r1 got=%0d exp=5", regs[1]);
    end
  endtask

  // ---- sequence and report ----
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_rd      = '0;
    cmd_rs1     = '0;
    cmd_rs2     = '0;
    cmd_addr    = '0;
    cmd_data    = '0;
    preset_en   = 1'b0;
    preset_idx  = '0;
    preset_val  = '0;
    #1;
    test_reset();
    test_memwr();
    test_load();
    test_add();
    test_mul();
    test_illegal_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
